seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one 7-segment driver bus among NDIG digit positions, each fed by its own counter/decoder instance (e74FSM-style segment codes). It steps round-robin over enabled digits, drives the shared segment lines and active-low digit anodes, and inserts a blanking interval at the start of each slot to suppress ghosting. It sits between the per-digit segment decoders and the board-level display pins.

Parameters:
NDIG, 4, number of digit positions; 2..8.
PRESCALE, 1000, CLK cycles per digit slot; must be >= 2 and > BLANK.
BLANK, 2, cycles at the start of each slot with all anodes off; 0..PRESCALE-1.

Ports:
CLK  in  1  system clock; all state changes on its rising edge.
RESET_N  in  1  reset, asynchronous, active-low.
EN  in  1  scan enable; 0 blanks the display and freezes the scan.
DIGIT_EN  in  NDIG  per-digit enable; bit i=1 includes digit i in the scan.
SEG_IN  in  7*NDIG  segment codes; bits [7i+6:7i] = {a,b,c,d,e,f,g} of digit i, active-low (0 = segment lit, e.g. "3" = 0000110).
SEG  out  7  shared segment bus {a,b,c,d,e,f,g}, active-low, registered.
AN  out  NDIG  digit anode selects, active-low one-hot, registered.
DIG_IDX  out  ceil(log2(NDIG))  index of the digit owning the current slot.
SLOT_TICK  out  1  one-cycle pulse in the last cycle of every slot.

Behaviour:
- Reset (RESET_N=0, asynchronous, no clock needed): state IDLE, slot counter 0, DIG_IDX=0, AN all 1, SEG=1111111, SLOT_TICK=0.
- States: IDLE, BLANK, DRIVE.
- IDLE: entered when EN=0 or DIGIT_EN=0. Slot counter held at 0, DIG_IDX held. Exit when EN=1 and DIGIT_EN!=0: select DIG_IDX if enabled, otherwise the next enabled index upward with wrap; go to BLANK (or directly to DRIVE if BLANK=0).
- Slot counter counts 0..PRESCALE-1 while not IDLE. Counts 0..BLANK-1 are state BLANK; counts BLANK..PRESCALE-1 are state DRIVE.
- At count PRESCALE-1: SLOT_TICK=1 for that cycle. On the next edge the counter returns to 0 and DIG_IDX advances to the next enabled index after the current one, searching upward with wrap from NDIG-1 to 0. With a single enabled digit, DIG_IDX stays put, but the blank interval still occurs every slot.
- Outputs are registered, one cycle behind state:
  - In DRIVE: AN = ~(onehot(DIG_IDX) & DIGIT_EN) and SEG = SEG_IN slice of DIG_IDX, both sampled each cycle, so mid-slot SEG_IN changes appear with 1-cycle latency.
  - In BLANK or IDLE: AN all 1 and SEG=1111111.
- At most one AN bit is 0 in any cycle. AN never selects a digit whose DIGIT_EN bit was 0 in the previous cycle.
- EN falls mid-slot: next state IDLE, counter cleared, outputs blank on the following cycle. When EN rises again, the same DIG_IDX gets a full fresh slot.
- DIGIT_EN bit of the current digit cleared mid-DRIVE: its anode turns off next cycle; the slot runs to completion, then the scan advances normally.
- DIGIT_EN becomes all-zero: go to IDLE as if EN=0.
- EN=1 together with an asynchronous reset assertion: reset wins.

Test Plan:
(Benches use NDIG=4, PRESCALE=4, BLANK=1, SEG_IN digits 0..3 = codes for 3,2,1,4.)
1. Assert RESET_N=0 between clock edges -> AN=1111, SEG=1111111, DIG_IDX=0 immediately; these values are held for 3 cycles after release while EN=0.
2. EN=1, DIGIT_EN=1111 -> repeating 4-cycle slots: 1 cycle AN=1111, then 3 cycles AN=1110/SEG=0000110; next slot AN=1101/SEG=0010010; then 1011/1001111; then 0111/1001100; wraps to digit 0. SLOT_TICK pulses every 4th cycle.
3. DIGIT_EN=0101 -> DIG_IDX sequence 0,2,0,2. AN is never 1101 or 0111.
4. EN=1, DIGIT_EN=0000 -> stays IDLE with all outputs blank. Then DIGIT_EN=1000 -> DIG_IDX=3 every slot, with 1 blank cycle + 3 cycles AN=0111 per slot.
5. Drop EN in the 2nd DRIVE cycle of digit 1 -> next cycle AN=1111 and the counter is 0. Raise EN 5 cycles later -> digit 1 gets a full slot (1 blank + 3 drive) before digit 2.
6. Assert RESET_N mid-DRIVE of digit 2 -> outputs blank asynchronously and DIG_IDX=0. After release with EN=1, the scan restarts at digit 0 with a blank cycle first.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: round-robin over enabled digits
// with a blanking interval at the start of every slot to suppress ghosting.
module seg_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 2
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      EN,
    input  logic [NDIG-1:0]           DIGIT_EN,
    input  logic [7*NDIG-1:0]         SEG_IN,
    output logic [6:0]                SEG,
    output logic [NDIG-1:0]           AN,
    output logic [$clog2(NDIG)-1:0]   DIG_IDX,
    output logic                      SLOT_TICK
);

    localparam int IW = $clog2(NDIG);
    localparam int CW = $clog2(PRESCALE);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

    localparam state_t SLOT_FIRST = (BLANK > 0) ? ST_BLANK : ST_DRIVE;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [IW-1:0]    dig_idx;
    logic [IW-1:0]    idx_nxt;
    logic [NDIG-1:0]  an_nxt;
    logic [6:0]       seg_nxt;
    logic             stop;
    logic             last;

    // Nearest enabled index at or above 'from' (skip=0) or strictly after it
    // (skip=1), wrapping; 'from' itself is the last candidate when skipping.
    function automatic logic [IW-1:0] next_enabled(
        input logic [IW-1:0]   from,
        input logic [NDIG-1:0] mask,
        input logic            skip
    );
        logic [IW-1:0] j;
        next_enabled = from;
        for (int k = NDIG; k >= 1; k--) begin
            j = IW'((int'(from) + k - 1 + int'(skip)) % NDIG);
            if (mask[j]) next_enabled = j;
        end
    endfunction

    assign stop      = !EN || (DIGIT_EN == '0);
    assign last      = (cnt == CW'(PRESCALE - 1));
    assign SLOT_TICK = (state != ST_IDLE) && last;
    assign DIG_IDX   = dig_idx;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dig_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dig_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = dig_idx;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!stop) begin
                    idx_nxt   = next_enabled(dig_idx, DIGIT_EN, 1'b0);
                    state_nxt = SLOT_FIRST;
                end
            end
            default: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (last) begin
                    cnt_nxt   = '0;
                    idx_nxt   = next_enabled(dig_idx, DIGIT_EN, 1'b1);
                    state_nxt = SLOT_FIRST;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = ((int'(cnt) + 1) < BLANK) ? ST_BLANK : ST_DRIVE;
                end
            end
        endcase
    end

    // Gating on the live enables blanks the pins the cycle after a disable.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = '1;
        if (state == ST_DRIVE && !stop) begin
            an_nxt  = ~((NDIG'(1) << dig_idx) & DIGIT_EN);
            seg_nxt = SEG_IN[7*int'(dig_idx) +: 7];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            AN  <= '1;
            SEG <= '1;
        end else begin
            AN  <= an_nxt;
            SEG <= seg_nxt;
        end
    end

endmodule
